// File: rtl/apb3_master_bridge.sv
// rtl/apb3_master_bridge.sv - valid/ready request channel to single APB3 transfers (optional APB_TIMEOUT_EN)
module apb3_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

`ifdef APB_TIMEOUT_EN
    // Abort fires on the ACCESS cycle whose low PREADY would make the count reach the limit.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign req_ready = (state_q == ST_IDLE) && !PRESET;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

    // Next-state logic: one APB transfer per accepted request, response held until taken.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_valid && req_ready) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    tmo_cnt_d   = tmo_cnt_q + 8'd1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // Wait-state counter for the ACCESS timeout.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
- Upstream neighbour of the APB3 configuration register slave.
- Converts a simple valid/ready request channel (from a CPU, debug or sequencer port) into single APB3 transfers. Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and samples PREADY/PRDATA/PSLVERR.
- Returns one response per request on a valid/ready response channel.
- Strictly one outstanding transfer.

Parameters:
- ADDR_W, 32, width of req_addr and PADDR.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort. Used only with APB_TIMEOUT_EN; legal range 1..255.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts request this cycle.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target address (word index, passed unchanged).
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  PSLVERR (or timeout) captured for this transfer.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous, active-high.
- Reset values (sampled at PCLK edge with PRESET=1):
  - state=IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter=0.
  - req_ready=0 while PRESET=1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- req_ready = (state==IDLE) && !PRESET, combinational. req_valid in any other state is ignored and not accepted.
- IDLE:
  - On req_valid&&req_ready, at that edge: capture req_addr→PADDR, req_write→PWRITE, req_wdata→PWDATA (captured even for reads); PSEL<=1, PENABLE<=0; go SETUP.
  - Otherwise PSEL=0, PENABLE=0.
- SETUP: exactly one cycle. PENABLE<=1; go ACCESS. PREADY is ignored in SETUP.
- ACCESS, PREADY sampled high at edge:
  - PSEL<=0, PENABLE<=0.
  - rsp_rdata<=PWRITE?0:PRDATA; rsp_err<=PSLVERR; rsp_valid<=1; go RESP.
- ACCESS, PREADY low: hold all APB outputs (wait states, unlimited unless APB_TIMEOUT_EN).
- RESP:
  - rsp_valid, rsp_rdata and rsp_err held stable until rsp_valid&&rsp_ready at an edge.
  - At that edge: rsp_valid<=0; go IDLE.
  - rsp_ready may already be high when rsp_valid rises; the response is then accepted at the first RESP edge.
- PADDR/PWRITE/PWDATA stable from SETUP through the final ACCESS cycle. After the transfer they retain their last values (no return to 0).
- Latency with zero-wait slave and rsp_ready=1:
  - Request accepted at edge t0; SETUP t0–t1; ACCESS t1–t2; rsp_valid high after t2; IDLE after t3.
  - Sustained throughput: one transfer per 4 cycles.
- PSLVERR is sampled only in the completing ACCESS cycle.
- Reset mid-operation (any state): next edge returns to IDLE with PSEL=PENABLE=0. Any pending response is discarded (rsp_valid=0).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on entering ACCESS, incremented each ACCESS cycle with PREADY low.
  - When the count reaches TIMEOUT_CYCLES with PREADY still low: PSEL<=0, PENABLE<=0, rsp_rdata<=0, rsp_err<=1, rsp_valid<=1; go RESP.
  - PREADY high in the same cycle as the limit takes priority: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write 0x12345678 to addr 0, PREADY=1, rsp_ready=1 → PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1 throughout; rsp_valid 1 cycle with rsp_rdata=0, rsp_err=0; next accept 4 cycles after the first.
- Read addr 1, slave PRDATA=0xCAFEF00D, PREADY low 3 ACCESS cycles then high → APB outputs stable for 4 ACCESS cycles; rsp_rdata=0xCAFEF00D, rsp_err=0.
- Read addr 5, PSLVERR=1 with PREADY → rsp_err=1, rsp_rdata=PRDATA (0xDEADBEEF from config slave default).
- rsp_ready held low 5 cycles after completion; req_valid high throughout → req_ready=0 and no new PSEL until response accepted; rsp fields unchanged over the 5 cycles.
- PRESET asserted in ACCESS with PREADY low → next cycle PSEL=PENABLE=0, rsp_valid=0, req_ready=0; after release req_ready=1 and a fresh read completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY tied 0 → abort after 4 ACCESS cycles: rsp_err=1, rsp_rdata=0. Without the macro, same stimulus: still in ACCESS after 100 cycles.
